// File: rtl/mem_resp.sv
// mem_resp: memory/IO responder for the exec stage.
// Bridges a 16-bit CPU request onto an 8-bit strobe/ack external bus. A word
// access becomes two byte cycles, low byte first, with exactly one idle
// strobe cycle between them.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   mem_op          request valid (held with its fields until mem_rdy)
//   addr[19:0]      byte address, or IO port number in addr[15:0]
//   wr_data[15:0]   write data (byte ops use [7:0])
//   we, m_io        write / IO-space select
//   byteop          1 = byte access, 0 = word access
//   memout[15:0]    read data, valid with mem_rdy, held until the next read
//   mem_rdy         one-cycle completion pulse
//   ext_addr/ext_wdata/ext_we/ext_io/ext_stb   external bus request
//   ext_ack/ext_rdata                          external bus response
//   bus_err         sticky watchdog timeout flag
//
// Build option: define MEM_RESP_TIMEOUT_EN to add a per-byte-cycle watchdog
// (parameter TO_CYCLES, default 255). A timed-out byte completes with 8'hFF
// and sets bus_err. Without it bus_err is tied 0 and the bus waits forever.
module mem_resp
`ifdef MEM_RESP_TIMEOUT_EN
  #(parameter int unsigned TO_CYCLES = 255)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op,
  input  logic [19:0] addr,
  input  logic [15:0] wr_data,
  input  logic        we,
  input  logic        m_io,
  input  logic        byteop,
  output logic [15:0] memout,
  output logic        mem_rdy,
  output logic [19:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  output logic        ext_io,
  output logic        ext_stb,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  logic        req_byte;
  logic [7:0]  req_hi;
  logic        byte_done;
  logic [7:0]  rd_byte;
  logic [19:0] next_addr;

  // ext_addr still holds the latched request address during LO.
  always_comb begin
    next_addr = ext_addr + 20'd1;
    if (ext_io) next_addr = {4'h0, ext_addr[15:0] + 16'd1};
  end

`ifdef MEM_RESP_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       timeout;

  always_comb begin
    timeout   = ext_stb && !ext_ack && (wd_cnt == 8'(TO_CYCLES - 1));
    byte_done = ext_stb && (ext_ack || timeout);
    rd_byte   = ext_ack ? ext_rdata : 8'hFF;
  end

  // Counter sits at zero while the strobe is low, so it restarts on every
  // strobe rise and counts the cycles the strobe waits for ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      if (!ext_stb || byte_done) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + 8'd1;
      if (timeout) bus_err <= 1'b1;
    end
  end
`else
  always_comb begin
    byte_done = ext_stb && ext_ack;
    rd_byte   = ext_rdata;
  end

  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      memout    <= '0;
      mem_rdy   <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      ext_we    <= 1'b0;
      ext_io    <= 1'b0;
      ext_stb   <= 1'b0;
      req_byte  <= 1'b0;
      req_hi    <= '0;
    end else begin
      mem_rdy <= 1'b0;
      case (state)
        IDLE: begin
          // The requester still holds the finished request during the
          // mem_rdy cycle, so it must not be taken as a new one.
          if (mem_op && !mem_rdy) begin
            state     <= LO;
            ext_stb   <= 1'b1;
            ext_addr  <= addr;
            ext_wdata <= wr_data[7:0];
            ext_we    <= we;
            ext_io    <= m_io;
            req_byte  <= byteop;
            req_hi    <= wr_data[15:8];
          end
        end
        LO: begin
          if (byte_done) begin
            ext_stb <= 1'b0;
            if (!ext_we) memout[7:0] <= rd_byte;
            if (req_byte) begin
              state <= DONE;
              if (!ext_we) memout[15:8] <= 8'h00;
            end else begin
              state     <= HI;
              ext_addr  <= next_addr;
              ext_wdata <= req_hi;
            end
          end
        end
        HI: begin
          // First HI cycle is the one-cycle strobe gap.
          if (!ext_stb) begin
            ext_stb <= 1'b1;
          end else if (byte_done) begin
            ext_stb <= 1'b0;
            if (!ext_we) memout[15:8] <= rd_byte;
            state <= DONE;
          end
        end
        DONE: begin
          mem_rdy <= 1'b1;
          ext_we  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
